// File: rtl/captura_pkg.sv
// Shared types and helpers for the keypad operand-capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package captura_pkg;

  typedef enum logic [1:0] {S_A, S_B, S_OUT} cap_state_t;

  // Largest key code that is a decimal digit; codes above it are ignored.
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

  // Widest entry the shift helper handles (8 BCD digits). Callers zero-extend
  // their entry to this width and truncate the result back to their own width.
  localparam int BCD_MAX_W = 32;

  // Append one BCD digit as the new least significant nibble.
  function automatic logic [BCD_MAX_W-1:0] bcd_shift_in(
    input logic [BCD_MAX_W-1:0] entry,
    input logic [3:0]           digit
  );
    return {entry[BCD_MAX_W-5:0], digit};
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// BCD entry shift register with digit count and a one-cycle overflow pulse.
// Latency: 1 clk from push_digit_i/clear_i to entry_o/count_o/overflow_o.
// Backpressure: none; a digit offered while full is dropped and flagged.
module bcd_entry_reg
  import captura_pkg::*;
#(
  parameter  int N_DIGITS = 3,
  localparam int W        = 4 * N_DIGITS,
  localparam int CW       = $clog2(N_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_digit_i,
  input  logic          clear_i,
  input  logic [3:0]    digit_i,
  output logic [W-1:0]  entry_o,
  output logic [CW-1:0] count_o,
  output logic          overflow_o
);

  logic [W-1:0]  entry_q, entry_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full;

  assign full = (count_q == CW'(N_DIGITS));

  // Next entry: clear wins over a digit; a digit into a full entry only pulses overflow.
  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clear_i) begin
      entry_d = '0;
      count_d = '0;
    end else if (push_digit_i) begin
      if (!full) begin
        entry_d = W'(bcd_shift_in(BCD_MAX_W'(entry_q), digit_i));
        count_d = count_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Entry, count and overflow registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign entry_o    = entry_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/captura_operandos.sv
// Builds BCD operands A and B from keypad events and offers the pair downstream.
// Latency: 2 clk from key_push to register update (strobe is registered first).
// Backpressure: ops_valid holds until ops_ready; keys arriving meanwhile are dropped.
module captura_operandos
  import captura_pkg::*;
#(
  parameter  int N_DIGITS = 3,
  localparam int W        = 4 * N_DIGITS,
  localparam int CW       = $clog2(N_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_push,
  input  logic [3:0]    key_digit,
  input  logic          key_clear,
  input  logic          key_save,
  output logic [W-1:0]  op_a,
  output logic [W-1:0]  op_b,
  output logic          ops_valid,
  input  logic          ops_ready,
  output logic [W-1:0]  entry,
  output logic [CW-1:0] entry_count,
  output logic          entry_sel,
  output logic          overflow
);

  cap_state_t   state_q, state_d;
  logic         key_stb_q;
  logic [W-1:0] op_a_q, op_a_d;
  logic [W-1:0] op_b_q, op_b_d;
  logic         ops_valid_q, ops_valid_d;

  logic         ev_clear, ev_save, ev_digit;
  logic         entry_empty;
  logic         push_digit, entry_clear;
  logic         handshake;

  // Flags are only meaningful in the strobe cycle; priority is clear > save > digit.
  assign ev_clear    = key_stb_q && key_clear;
  assign ev_save     = key_stb_q && !key_clear && key_save;
  assign ev_digit    = key_stb_q && !key_clear && !key_save && (key_digit <= KEY_MAX_DIGIT);
  assign entry_empty = (entry_count == '0);
  assign handshake   = ops_valid_q && ops_ready;

  // Register the keypad strobe so decode lines up with the digit/flag data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) key_stb_q <= 1'b0;
    else      key_stb_q <= key_push;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_A;
    else      state_q <= state_d;
  end

  // FSM next state: save advances A->B->OUT, clear on an empty B backs out to A.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_A: begin
        if (ev_save && !entry_empty) state_d = S_B;
      end
      S_B: begin
        if (ev_clear && entry_empty)      state_d = S_A;
        else if (ev_save && !entry_empty) state_d = S_OUT;
      end
      S_OUT: begin
        if (handshake) state_d = S_A;
      end
      default: state_d = S_A;
    endcase
  end

  // FSM outputs: entry controls and next values of the operand/valid registers.
  always_comb begin
    push_digit  = 1'b0;
    entry_clear = 1'b0;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    ops_valid_d = ops_valid_q;
    unique case (state_q)
      S_A: begin
        push_digit = ev_digit;
        if (ev_clear) entry_clear = 1'b1;
        if (ev_save && !entry_empty) begin
          op_a_d      = entry;
          entry_clear = 1'b1;
        end
      end
      S_B: begin
        push_digit = ev_digit;
        if (ev_clear) begin
          entry_clear = 1'b1;
          if (entry_empty) op_a_d = '0;
        end
        if (ev_save && !entry_empty) begin
          op_b_d      = entry;
          entry_clear = 1'b1;
          ops_valid_d = 1'b1;
        end
      end
      S_OUT: begin
        // Keys are ignored here; operands stay put after the handshake.
        if (handshake) ops_valid_d = 1'b0;
      end
      default: ops_valid_d = 1'b0;
    endcase
  end

  // Operand and valid registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      ops_valid_q <= 1'b0;
    end else begin
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      ops_valid_q <= ops_valid_d;
    end
  end

  bcd_entry_reg #(
    .N_DIGITS (N_DIGITS)
  ) u_entry (
    .clk          (clk),
    .rst          (rst),
    .push_digit_i (push_digit),
    .clear_i      (entry_clear),
    .digit_i      (key_digit),
    .entry_o      (entry),
    .count_o      (entry_count),
    .overflow_o   (overflow)
  );

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign ops_valid = ops_valid_q;
  assign entry_sel = (state_q == S_B);

endmodule

// File: tb/tb_captura_operandos.sv
// Self-checking bench for captura_operandos: directed scenarios plus random key streams.
// Reference model keeps the entry as a list of decimal digits and the phase as an int.
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.
module tb_captura_operandos;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_push;
  logic [3:0]  key_digit;
  logic        key_clear;
  logic        key_save;
  logic [11:0] op_a, op_b, entry;
  logic        ops_valid, ops_ready;
  logic [1:0]  entry_count;
  logic        entry_sel;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0 = entering A, 1 = entering B, 2 = pair offered.
  int          m_st;
  int          m_ent[$];
  logic [11:0] m_a, m_b;
  bit          m_vld, m_ovf;

  captura_operandos #(.N_DIGITS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_push    (key_push),
    .key_digit   (key_digit),
    .key_clear   (key_clear),
    .key_save    (key_save),
    .op_a        (op_a),
    .op_b        (op_b),
    .ops_valid   (ops_valid),
    .ops_ready   (ops_ready),
    .entry       (entry),
    .entry_count (entry_count),
    .entry_sel   (entry_sel),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Decimal value of the digits typed so far, re-encoded as three BCD nibbles.
  function automatic logic [11:0] ent_bcd();
    int v = 0;
    logic [11:0] r = '0;
    foreach (m_ent[i]) v = v * 10 + m_ent[i];
    for (int k = 0; k < 3; k++) begin
      r[k*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_st = 0; m_ent.delete(); m_a = '0; m_b = '0; m_vld = 0; m_ovf = 0;
  endtask

  task automatic model_key(input logic [3:0] d, input bit c, input bit s);
    m_ovf = 0;
    if (m_st == 2) return;
    if (c) begin
      if (m_st == 1 && m_ent.size() == 0) begin
        m_a = '0;
        m_st = 0;
      end
      m_ent.delete();
    end else if (s) begin
      if (m_ent.size() > 0) begin
        if (m_st == 0) begin
          m_a = ent_bcd();
          m_st = 1;
        end else begin
          m_b = ent_bcd();
          m_st = 2;
          m_vld = 1;
        end
        m_ent.delete();
      end
    end else if (d <= 4'd9) begin
      if (m_ent.size() < 3) m_ent.push_back(int'(d));
      else m_ovf = 1;
    end
  endtask

  // One key event; flags go to random levels afterwards (they may be sticky upstream).
  task automatic drive_key(input logic [3:0] d, input bit c, input bit s);
    @(posedge clk); #1;
    key_push = 1'b1; key_digit = d; key_clear = c; key_save = s;
    @(posedge clk); #1;
    key_push = 1'b0;
    @(posedge clk); #1;
    key_digit = 4'($urandom); key_clear = 1'($urandom); key_save = 1'($urandom);
    model_key(d, c, s);
    @(negedge clk);
  endtask

  task automatic do_handshake();
    @(posedge clk); #1; ops_ready = 1'b1;
    @(posedge clk); #1; ops_ready = 1'b0;
    if (m_st == 2) begin m_st = 0; m_vld = 0; end
    m_ovf = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; key_push = 1'b0; key_digit = '0; key_clear = 1'b0; key_save = 1'b0;
    ops_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (op_a !== 12'h000) begin failures++; $display("FAIL reset_op_a got=%h exp=000", op_a); end
    checks++; if (op_b !== 12'h000) begin failures++; $display("FAIL reset_op_b got=%h exp=000", op_b); end
    checks++; if (entry !== 12'h000) begin failures++; $display("FAIL reset_entry got=%h exp=000", entry); end
    checks++; if (entry_count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", entry_count); end
    checks++; if (ops_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ops_valid); end
    checks++; if (entry_sel !== 1'b0) begin failures++; $display("FAIL reset_sel got=%b exp=0", entry_sel); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic test_basic_pair();
    drive_key(4'd1, 0, 0); drive_key(4'd2, 0, 0); drive_key(4'd3, 0, 0);
    checks++; if (entry !== 12'h123) begin failures++; $display("FAIL pair_entry got=%h exp=123", entry); end
    drive_key(4'd0, 0, 1);
    checks++; if (op_a !== 12'h123) begin failures++; $display("FAIL pair_op_a got=%h exp=123", op_a); end
    checks++; if (entry_sel !== 1'b1) begin failures++; $display("FAIL pair_sel_b got=%b exp=1", entry_sel); end
    drive_key(4'd4, 0, 0); drive_key(4'd5, 0, 0); drive_key(4'd0, 0, 1);
    checks++; if (op_b !== 12'h045) begin failures++; $display("FAIL pair_op_b got=%h exp=045", op_b); end
    checks++; if (ops_valid !== 1'b1) begin failures++; $display("FAIL pair_valid got=%b exp=1", ops_valid); end
    checks++; if (entry !== 12'h000) begin failures++; $display("FAIL pair_entry_clr got=%h exp=000", entry); end
    do_handshake();
    checks++; if (ops_valid !== 1'b0) begin failures++; $display("FAIL pair_valid_drop got=%b exp=0", ops_valid); end
    checks++; if (entry_sel !== 1'b0) begin failures++; $display("FAIL pair_sel_a got=%b exp=0", entry_sel); end
    checks++; if (op_a !== 12'h123 || op_b !== 12'h045) begin
      failures++; $display("FAIL pair_retained got=%h/%h exp=123/045", op_a, op_b); end
  endtask

  task automatic test_overflow();
    drive_key(4'd9, 0, 0); drive_key(4'd8, 0, 0); drive_key(4'd7, 0, 0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    drive_key(4'd6, 0, 0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
    checks++; if (entry !== 12'h987) begin failures++; $display("FAIL ovf_entry got=%h exp=987", entry); end
    checks++; if (entry_count !== 2'd3) begin failures++; $display("FAIL ovf_count got=%0d exp=3", entry_count); end
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_one_cycle got=%b exp=0", overflow); end
    drive_key(4'd0, 1, 0);
  endtask

  task automatic test_clear_entry();
    drive_key(4'd7, 0, 0);
    drive_key(4'd0, 1, 0);
    checks++; if (entry !== 12'h000 || entry_count !== 2'd0) begin
      failures++; $display("FAIL clr_entry got=%h/%0d exp=000/0", entry, entry_count); end
    drive_key(4'd5, 0, 0);
    drive_key(4'd0, 0, 1);
    checks++; if (op_a !== 12'h005) begin failures++; $display("FAIL clr_op_a got=%h exp=005", op_a); end
  endtask

  task automatic test_backout();
    drive_key(4'd0, 1, 0);
    checks++; if (entry_sel !== 1'b0) begin failures++; $display("FAIL backout_sel got=%b exp=0", entry_sel); end
    checks++; if (op_a !== 12'h000) begin failures++; $display("FAIL backout_op_a got=%h exp=000", op_a); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1; key_push = 1'b1; key_clear = 1'b0; key_save = 1'b0; key_digit = 4'hF;
    @(posedge clk); #1; key_digit = 4'd4;
    @(posedge clk); #1; key_digit = 4'd0;
    @(posedge clk); #1; key_push = 1'b0; key_digit = 4'd2;
    @(posedge clk); #1; key_digit = 4'hC;
    model_key(4'd4, 0, 0); model_key(4'd0, 0, 0); model_key(4'd2, 0, 0);
    @(negedge clk);
    checks++; if (entry !== ent_bcd() || entry !== 12'h402) begin
      failures++; $display("FAIL b2b_entry got=%h exp=402", entry); end
    checks++; if (entry_count !== 2'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", entry_count); end
    drive_key(4'd0, 1, 0);
  endtask

  task automatic test_out_hold();
    drive_key(4'd1, 0, 1'b0); drive_key(4'd0, 0, 1);
    drive_key(4'd2, 0, 0);    drive_key(4'd0, 0, 1);
    drive_key(4'd3, 0, 0);
    drive_key(4'd0, 1, 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checks++; if (ops_valid !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, ops_valid); end
    end
    checks++; if (op_a !== 12'h001 || op_b !== 12'h002 || entry !== 12'h000) begin
      failures++; $display("FAIL hold_stable got=%h/%h/%h exp=001/002/000", op_a, op_b, entry); end
    // Key strobe lands in the same cycle the handshake completes: key must be dropped.
    @(posedge clk); #1; key_push = 1'b1; key_digit = 4'd9; key_clear = 1'b0; key_save = 1'b0;
    @(posedge clk); #1; key_push = 1'b0; ops_ready = 1'b1;
    @(posedge clk); #1; ops_ready = 1'b0;
    m_st = 0; m_vld = 0; m_ovf = 0;
    @(negedge clk);
    checks++; if (ops_valid !== 1'b0 || entry_sel !== 1'b0) begin
      failures++; $display("FAIL simul_hs got=%b/%b exp=0/0", ops_valid, entry_sel); end
    checks++; if (entry !== 12'h000 || entry_count !== 2'd0) begin
      failures++; $display("FAIL simul_key_dropped got=%h/%0d exp=000/0", entry, entry_count); end
  endtask

  task automatic test_async_reset();
    drive_key(4'd1, 0, 0); drive_key(4'd0, 0, 1);
    drive_key(4'd0, 0, 0); drive_key(4'd1, 0, 0); drive_key(4'd2, 0, 0);
    checks++; if (entry !== 12'h012 || entry_sel !== 1'b1) begin
      failures++; $display("FAIL arst_setup got=%h/%b exp=012/1", entry, entry_sel); end
    @(posedge clk); #3; rst = 1'b0;
    #1;
    checks++; if (entry !== 12'h000 || entry_count !== 2'd0 || entry_sel !== 1'b0 ||
                  op_a !== 12'h000 || op_b !== 12'h000 || ops_valid !== 1'b0) begin
      failures++; $display("FAIL arst_immediate got=%h/%0d/%b/%h/%h/%b exp=0", entry, entry_count,
                           entry_sel, op_a, op_b, ops_valid); end
    #3; rst = 1'b1;
    model_reset();
    drive_key(4'd0, 0, 1);
    checks++; if (entry_sel !== 1'b0 || op_a !== 12'h000 || ops_valid !== 1'b0) begin
      failures++; $display("FAIL arst_empty_save got=%b/%h/%b exp=0/000/0", entry_sel, op_a, ops_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      if (m_st == 2 && $urandom_range(0, 1) == 1) begin
        do_handshake();
      end else begin
        int r = $urandom_range(0, 9);
        logic [3:0] d = 4'($urandom_range(0, 12));
        if (r == 0)      drive_key(d, 1, 0);
        else if (r <= 2) drive_key(d, 0, 1);
        else             drive_key(d, 0, 0);
      end
      checks++; if (entry !== ent_bcd()) begin failures++; $display("FAIL rnd_entry n=%0d got=%h exp=%h", n, entry, ent_bcd()); end
      checks++; if (entry_count !== 2'(m_ent.size())) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, entry_count, m_ent.size()); end
      checks++; if (entry_sel !== (m_st == 1)) begin failures++; $display("FAIL rnd_sel n=%0d got=%b exp=%b", n, entry_sel, m_st == 1); end
      checks++; if (ops_valid !== m_vld) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, ops_valid, m_vld); end
      checks++; if (op_a !== m_a) begin failures++; $display("FAIL rnd_op_a n=%0d got=%h exp=%h", n, op_a, m_a); end
      checks++; if (op_b !== m_b) begin failures++; $display("FAIL rnd_op_b n=%0d got=%h exp=%h", n, op_b, m_b); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_overflow();
    test_clear_entry();
    test_backout();
    test_back_to_back();
    test_out_hold();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/captura_operandos.md
Name: captura_operandos

Overview:
Downstream consumer of the keypad reader. Turns accepted key events into two multi-digit BCD operands, A and B.
- Digits 0-9 are appended to the current entry.
- '*' clears the entry; '#' commits it.
- After both operands are committed, they are presented to the arithmetic/display stage through a valid/ready handshake.
- A live view of the entry in progress is exported for the 7-segment driver.

Parameters:
N_DIGITS, 3, maximum BCD digits per operand.
W, 4*N_DIGITS (derived, localparam), operand width in bits.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous active-low reset; 0 = reset asserted.
key_push  input  1  one-cycle strobe from keypad reader, one per accepted key.
key_digit  input  4  digit code of the key; valid from the cycle after key_push.
key_clear  input  1  '*' flag; valid from the cycle after key_push.
key_save  input  1  '#' flag; valid from the cycle after key_push.
op_a  output  W  committed operand A, BCD, most significant digit in the top nibble.
op_b  output  W  committed operand B, BCD.
ops_valid  output  1  op_a/op_b pair available.
ops_ready  input  1  downstream accepts the pair when ops_valid && ops_ready.
entry  output  W  BCD entry in progress (display view).
entry_count  output  $clog2(N_DIGITS+1)  digits currently in entry.
entry_sel  output  1  0 = entering A, 1 = entering B.
overflow  output  1  one-cycle pulse when a digit is dropped because the entry is full.

Behaviour:
- Reset (rst=0, async): state=S_A; op_a, op_b, entry = 0; entry_count=0; ops_valid=0; overflow=0; key_push pipe=0.
- Key sampling: key_push is registered into key_stb. All decode happens in the cycle where key_stb=1, using key_digit/key_clear/key_save as sampled in that cycle. Total latency is 2 clk from key_push to the register update.
- Decode priority at key_stb: clear > save > digit. A digit code >9 with no flag set is ignored (no state change).
- Digit (state S_A or S_B):
  - If entry_count<N_DIGITS: entry <= {entry[W-5:0], key_digit}; entry_count += 1.
  - Otherwise: entry is unchanged and overflow=1 for exactly one cycle.
- Clear:
  - In S_A or S_B: entry=0, entry_count=0.
  - In S_B with entry_count already 0: additionally op_a=0 and state goes to S_A (backs out to operand A).
- Save, state S_A:
  - If entry_count>0: op_a<=entry; entry/count cleared; state goes to S_B.
  - If entry_count=0: ignored.
- Save, state S_B:
  - If entry_count>0: op_b<=entry; entry/count cleared; state goes to S_OUT; ops_valid<=1 in the same update.
  - If entry_count=0: ignored.
- State S_OUT:
  - ops_valid held high; op_a/op_b stable.
  - On ops_valid && ops_ready: ops_valid<=0; state goes to S_A; op_a and op_b are retained (visible to downstream until overwritten).
  - All key events in S_OUT are ignored, including clear.
- Simultaneous events: key_stb is evaluated in the same cycle as ops_ready → both apply; a key arriving in S_OUT is still ignored, even if the handshake completes that cycle.
- entry_sel = (state==S_B).
- entry_count never exceeds N_DIGITS.
- Back-to-back key_push on consecutive cycles is legal; each is processed in order.
- Reset mid-operation: all partial entries are discarded; no ops_valid glitch.
- Upstream flags may be sticky levels. Only the key_stb cycle is qualifying; flags are never acted on outside key_stb.

Decomposition:
- Package captura_pkg:
  - typedef enum logic [1:0] {S_A, S_B, S_OUT} cap_state_t.
  - localparam KEY_MAX_DIGIT=4'd9.
  - Function bcd_shift_in(entry, digit).
- One sub-module: bcd_entry_reg. Holds the entry shift register, entry_count and the overflow pulse, with controls push_digit/clear. It is instantiated once; the FSM and operand registers stay in the top.

Test Plan:
- Keys 1,2,3,#,4,5,# then ops_ready=1 → op_a=12'h123, op_b=12'h045, ops_valid for 1 handshake, then state S_A.
- Keys 9,8,7,6 → entry=12'h987, overflow pulses once on the 4th digit, entry_count=3.
- Keys 7,*,5,# → op_a=12'h005; '*' cleared the entry to 0 with count 0 before the 5.
- In S_B with empty entry, press * → state S_A, op_a=0, entry_sel=0.
- In S_OUT hold ops_ready=0 for 20 cycles while pressing 3 and * → ops_valid stays 1, op_a/op_b/entry unchanged.
- Pull rst low asynchronously mid-entry (entry=12'h012, S_B) → all outputs 0 immediately; '#' with empty entry after release is ignored.
